// File: rtl/common.sv
// common: shared cache-bus types used by the caches and the memory responder.
//   cbus_req_t  : initiator -> memory (valid, is_write, size, addr, strobe, data, len, burst)
//   cbus_resp_t : memory -> initiator (ready, last, data)
//   mlen_t      : burst length encoded as beats-1
//   axi_burst_type_t : FIXED keeps the address, INCR advances one word per beat
package common;

  typedef logic [31:0] addr_t;

  typedef enum logic [7:0] {
    MLEN1  = 8'd0,
    MLEN2  = 8'd1,
    MLEN4  = 8'd3,
    MLEN8  = 8'd7,
    MLEN16 = 8'd15
  } mlen_t;

  typedef enum logic [1:0] {
    AXI_BURST_FIXED = 2'b00,
    AXI_BURST_INCR  = 2'b01,
    AXI_BURST_WRAP  = 2'b10
  } axi_burst_type_t;

  localparam logic [2:0] MSIZE1 = 3'd0;
  localparam logic [2:0] MSIZE2 = 3'd1;
  localparam logic [2:0] MSIZE4 = 3'd2;
  localparam logic [2:0] MSIZE8 = 3'd3;

  typedef struct packed {
    logic            valid;
    logic            is_write;
    logic [2:0]      size;
    addr_t           addr;
    logic [7:0]      strobe;
    logic [63:0]     data;
    mlen_t           len;
    axi_burst_type_t burst;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [63:0] data;
  } cbus_resp_t;

endpackage

// File: rtl/RAM_SinglePort.sv
// RAM_SinglePort: single-port RAM with per-byte write enables.
//   clk    : clock
//   en     : port enable (gates writes and the registered read)
//   strobe : per-byte write enables
//   addr   : word address
//   wdata  : write data
//   rdata  : read data; combinational when READ_LATENCY==0, else registered
// Contents are never reset.
module RAM_SinglePort #(
  parameter int unsigned ADDR_WIDTH   = 10,
  parameter int unsigned DATA_WIDTH   = 64,
  parameter int unsigned BYTE_WIDTH   = 8,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic                             clk,
  input  logic                             en,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] strobe,
  input  logic [ADDR_WIDTH-1:0]            addr,
  input  logic [DATA_WIDTH-1:0]            wdata,
  output logic [DATA_WIDTH-1:0]            rdata
);

  localparam int unsigned NBYTES = DATA_WIDTH / BYTE_WIDTH;

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (en) begin
      for (int unsigned i = 0; i < NBYTES; i++) begin
        if (strobe[i]) begin
          mem[addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= wdata[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
    end
  end

  generate
    if (READ_LATENCY == 0) begin : g_comb_read
      assign rdata = mem[addr];
    end else begin : g_reg_read
      always_ff @(posedge clk) begin
        if (en) begin
          rdata <= mem[addr];
        end
      end
    end
  endgenerate

endmodule

// File: rtl/cbus_mem_responder_stall_lfsr.sv
// cbus_stall_lfsr: pseudo-random stall source for the cbus memory responder.
//   clk   : clock
//   reset : asynchronous active-low reset (reloads seed 16'hACE1)
//   stall : high when the low two LFSR bits are 00 (about one cycle in four)
module cbus_stall_lfsr (
  input  logic clk,
  input  logic reset,
  output logic stall
);

  logic [15:0] lfsr;

  // Maximal-length taps 16,14,13,11; advances every cycle regardless of bus activity.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lfsr <= 16'hACE1;
    end else begin
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
  end

  assign stall = (lfsr[1:0] == 2'b00);

endmodule

// File: rtl/cbus_mem_responder.sv
// cbus_mem_responder: memory end of the cache-bus burst protocol, backed by a
// word-addressed 64-bit RAM with zero-latency reads.
//   clk   : clock
//   reset : asynchronous active-low reset (RAM contents are kept)
//   creq  : cbus request (held stable by the initiator until after the last beat)
//   cresp : cbus response; one beat per cycle with ready=1, last marks the final beat
// Build option: define CBUS_RANDOM_STALL_EN to insert pseudo-random ready stalls.
module cbus_mem_responder
  import common::*;
#(
  parameter int unsigned ADDR_WORD_BITS     = 12,
  parameter int unsigned FIRST_BEAT_LATENCY = 2,
  parameter int unsigned MAX_BEATS          = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  cbus_req_t  creq,
  output cbus_resp_t cresp
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_BEAT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  typedef enum logic [1:0] {
    IDLE = S_IDLE,
    WAIT = S_WAIT,
    BEAT = S_BEAT,
    DONE = S_DONE
  } state_t;

  localparam int unsigned BL_W = $clog2(MAX_BEATS + 1);
  localparam logic [3:0]  LAT0 = 4'(FIRST_BEAT_LATENCY);

  state_t                  state;
  logic [BL_W-1:0]         beats_left;
  logic [ADDR_WORD_BITS-1:0] idx;
  logic [3:0]              lat;
  logic                    is_write_q;
  axi_burst_type_t         burst_q;

  logic [31:0]             req_beats;
  logic [31:0]             clip_beats;
  logic                    stall;
  logic                    beat_fire;
  logic [7:0]              ram_we;
  logic [63:0]             ram_rdata;
  logic                    unused_req;

  // size and the address bits outside the word index carry no meaning here.
  assign unused_req = ^{creq.size, creq.addr};

`ifdef CBUS_RANDOM_STALL_EN
  cbus_stall_lfsr u_stall (
    .clk   (clk),
    .reset (reset),
    .stall (stall)
  );
`else
  assign stall = 1'b0;
`endif

  always_comb begin
    req_beats  = 32'(creq.len) + 32'd1;
    clip_beats = (req_beats > 32'(MAX_BEATS)) ? 32'(MAX_BEATS) : req_beats;
  end

  // A beat only happens while the initiator still holds valid; a dropped
  // valid neither shows ready nor commits a write.
  assign beat_fire = (state == BEAT) && creq.valid && !stall;
  assign ram_we    = {8{beat_fire && is_write_q}} & creq.strobe;

  RAM_SinglePort #(
    .ADDR_WIDTH   (ADDR_WORD_BITS),
    .DATA_WIDTH   (64),
    .BYTE_WIDTH   (8),
    .READ_LATENCY (0)
  ) u_ram (
    .clk    (clk),
    .en     (beat_fire),
    .strobe (ram_we),
    .addr   (idx),
    .wdata  (creq.data),
    .rdata  (ram_rdata)
  );

  always_comb begin
    cresp       = '0;
    cresp.ready = beat_fire;
    cresp.last  = beat_fire && (beats_left == BL_W'(1));
    cresp.data  = (beat_fire && !is_write_q) ? ram_rdata : '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      beats_left <= '0;
      idx        <= '0;
      lat        <= '0;
      is_write_q <= 1'b0;
      burst_q    <= AXI_BURST_FIXED;
    end else begin
      case (state)
        IDLE: begin
          if (creq.valid) begin
            is_write_q <= creq.is_write;
            burst_q    <= creq.burst;
            beats_left <= BL_W'(clip_beats);
            idx        <= creq.addr[3 +: ADDR_WORD_BITS];
            lat        <= LAT0;
            if (FIRST_BEAT_LATENCY == 0) begin
              state <= BEAT;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (!creq.valid) begin
            state <= IDLE;
          end else begin
            lat <= lat - 4'd1;
            if (lat == 4'd1) begin
              state <= BEAT;
            end
          end
        end
        BEAT: begin
          if (!creq.valid) begin
            state <= IDLE;
          end else if (!stall) begin
            beats_left <= beats_left - BL_W'(1);
            // Anything other than FIXED advances linearly, wrapping at the top of RAM.
            if (burst_q != AXI_BURST_FIXED) begin
              idx <= idx + ADDR_WORD_BITS'(1);
            end
            if (beats_left == BL_W'(1)) begin
              state <= DONE;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cbus_mem_responder.sv
`timescale 1ns/1ps
module tb_cbus_mem_responder;
  import common::*;

  localparam int unsigned AW_A = 12;
  localparam int unsigned AW_B = 4;
  localparam int unsigned LAT  = 2;
  localparam int unsigned MAXB = 16;
  localparam int unsigned NONE = 99;

  logic       clk = 1'b0;
  logic       rst_n;
  cbus_req_t  creq;
  cbus_resp_t resp_a;
  cbus_resp_t resp_b;

  int total = 0;
  int bad   = 0;

  logic [63:0] mem_a [2**AW_A];
  logic [63:0] mem_b [2**AW_B];
  logic [63:0] wbuf  [MAXB];

  always #5 clk = ~clk;

  cbus_mem_responder #(
    .ADDR_WORD_BITS     (AW_A),
    .FIRST_BEAT_LATENCY (LAT),
    .MAX_BEATS          (MAXB)
  ) dut_a (
    .clk   (clk),
    .reset (rst_n),
    .creq  (creq),
    .cresp (resp_a)
  );

  cbus_mem_responder #(
    .ADDR_WORD_BITS     (AW_B),
    .FIRST_BEAT_LATENCY (LAT),
    .MAX_BEATS          (MAXB)
  ) dut_b (
    .clk   (clk),
    .reset (rst_n),
    .creq  (creq),
    .cresp (resp_b)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] nw,
                                        input logic [7:0] strb);
    logic [63:0] r;
    r = old;
    for (int i = 0; i < 8; i++) begin
      if (strb[i]) r[i*8 +: 8] = nw[i*8 +: 8];
    end
    return r;
  endfunction

  // abort_mode: 0 none, 1 drop valid at beat abort_at, 2 assert reset at beat abort_at
  task automatic run_txn(input logic wr, input logic [31:0] addr, input logic [7:0] len,
                         input logic [1:0] burst, input logic [7:0] strb,
                         input int unsigned abort_at, input int unsigned abort_mode);
    int unsigned nb, beat, cyc, ia, ib;
    bit done;
    nb = 32'(len) + 1;
    if (nb > MAXB) nb = MAXB;
    ia   = 32'(addr[3 +: AW_A]);
    ib   = 32'(addr[3 +: AW_B]);
    beat = 0;
    cyc  = 0;
    done = 1'b0;
    creq.valid    = 1'b1;
    creq.is_write = wr;
    creq.size     = MSIZE8;
    creq.addr     = addr;
    creq.strobe   = strb;
    creq.data     = wbuf[0];
    creq.len      = mlen_t'(len);
    creq.burst    = axi_burst_type_t'(burst);
    while (!done) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc > 200) begin
        chk("beat_timeout", 64'(cyc), 64'(200));
        creq.valid = 1'b0;
        return;
      end
`ifndef CBUS_RANDOM_STALL_EN
      chk("ready_timing_a", 64'(resp_a.ready), 64'(cyc >= LAT + 1));
      chk("ready_timing_b", 64'(resp_b.ready), 64'(cyc >= LAT + 1));
`endif
      if (abort_mode != 0 && resp_a.ready && beat == abort_at) begin
        if (abort_mode == 1) begin
          creq.valid = 1'b0;
          #1;
          chk("drop_ready_a", 64'(resp_a.ready), 64'(0));
          chk("drop_ready_b", 64'(resp_b.ready), 64'(0));
          @(posedge clk); #1;
          chk("drop_idle_a", 64'(resp_a.ready), 64'(0));
          chk("drop_idle_b", 64'(resp_b.ready), 64'(0));
        end else begin
          rst_n = 1'b0;
          #1;
          chk("rst_ready_a", 64'(resp_a.ready), 64'(0));
          chk("rst_last_a", 64'(resp_a.last), 64'(0));
          chk("rst_data_a", resp_a.data, 64'(0));
          chk("rst_ready_b", 64'(resp_b.ready), 64'(0));
          chk("rst_last_b", 64'(resp_b.last), 64'(0));
          @(posedge clk); #1;
          rst_n = 1'b1;
          creq.valid = 1'b0;
        end
        return;
      end
      if (resp_a.ready) begin
        chk("last_a", 64'(resp_a.last), 64'(beat == nb - 1));
        chk("last_b", 64'(resp_b.last), 64'(beat == nb - 1));
        if (!wr) begin
          chk("rdata_a", resp_a.data, mem_a[ia]);
          chk("rdata_b", resp_b.data, mem_b[ib]);
        end else begin
          creq.data = wbuf[beat];
          mem_a[ia] = merge(mem_a[ia], wbuf[beat], strb);
          mem_b[ib] = merge(mem_b[ib], wbuf[beat], strb);
        end
        beat++;
        if (burst != 2'b00) begin
          ia = (ia + 1) % (2**AW_A);
          ib = (ib + 1) % (2**AW_B);
        end
        if (beat == nb) done = 1'b1;
      end else begin
        chk("idle_data_a", resp_a.data, 64'(0));
        chk("idle_last_a", 64'(resp_a.last), 64'(0));
        chk("idle_data_b", resp_b.data, 64'(0));
      end
    end
`ifndef CBUS_RANDOM_STALL_EN
    chk("txn_cycles", 64'(cyc), 64'(nb + LAT));
`else
    chk("txn_cycles_min", 64'(cyc >= nb + LAT), 64'(1));
`endif
    // DONE: valid still held high, must be ignored
    @(posedge clk); #1;
    chk("done_ready_a", 64'(resp_a.ready), 64'(0));
    chk("done_data_a", resp_a.data, 64'(0));
    chk("done_ready_b", 64'(resp_b.ready), 64'(0));
    @(posedge clk); #1;
    chk("post_ready_a", 64'(resp_a.ready), 64'(0));
    creq.valid = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ra;
    logic [7:0]  rl;
    logic [1:0]  rb;
    logic [7:0]  rs;
    logic        rw;

    rst_n = 1'b0;
    creq  = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ready_a", 64'(resp_a.ready), 64'(0));
    chk("reset_last_a", 64'(resp_a.last), 64'(0));
    chk("reset_data_a", resp_a.data, 64'(0));
    chk("reset_ready_b", 64'(resp_b.ready), 64'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Fill the whole RAM so every later read has a defined expectation.
    for (int i = 0; i < 256; i++) begin
      for (int j = 0; j < 16; j++) wbuf[j] = {$urandom, $urandom};
      run_txn(1'b1, 32'(i * 128), 8'd15, 2'b01, 8'hFF, NONE, 0);
    end

    // Single read of word 5.
    wbuf[0] = 64'h1122334455667788;
    run_txn(1'b1, 32'h28, 8'd0, 2'b00, 8'hFF, NONE, 0);
    run_txn(1'b0, 32'h28, 8'd0, 2'b00, 8'hFF, NONE, 0);

    // 16-beat INCR write of 0..15, then read back.
    for (int j = 0; j < 16; j++) wbuf[j] = 64'(j);
    run_txn(1'b1, 32'h80, 8'd15, 2'b01, 8'hFF, NONE, 0);
    run_txn(1'b0, 32'h80, 8'd15, 2'b01, 8'hFF, NONE, 0);

    // Strobe merge into word 0.
    wbuf[0] = 64'hFFFF_FFFF_FFFF_FFFF;
    run_txn(1'b1, 32'h0, 8'd0, 2'b00, 8'hFF, NONE, 0);
    wbuf[0] = 64'h0;
    run_txn(1'b1, 32'h0, 8'd0, 2'b00, 8'h0F, NONE, 0);
    run_txn(1'b0, 32'h0, 8'd0, 2'b00, 8'hFF, NONE, 0);

    // INCR from word 14: small RAM wraps to 0,1.
    for (int j = 0; j < 4; j++) wbuf[j] = {$urandom, $urandom};
    run_txn(1'b1, 32'h70, 8'd3, 2'b01, 8'hFF, NONE, 0);
    run_txn(1'b0, 32'h70, 8'd3, 2'b01, 8'hFF, NONE, 0);
    run_txn(1'b0, 32'h0, 8'd1, 2'b01, 8'hFF, NONE, 0);

    // FIXED 4-beat write to word 2, check neighbours.
    for (int j = 0; j < 4; j++) wbuf[j] = 64'(j + 1);
    run_txn(1'b1, 32'h10, 8'd3, 2'b00, 8'hFF, NONE, 0);
    run_txn(1'b0, 32'h08, 8'd2, 2'b01, 8'hFF, NONE, 0);

    // Strobe 0 write leaves memory unchanged.
    for (int j = 0; j < 4; j++) wbuf[j] = {$urandom, $urandom};
    run_txn(1'b1, 32'h200, 8'd3, 2'b01, 8'h00, NONE, 0);
    run_txn(1'b0, 32'h200, 8'd3, 2'b01, 8'hFF, NONE, 0);

    // High address bits alias.
    wbuf[0] = 64'hDEAD_BEEF_0BAD_F00D;
    run_txn(1'b1, 32'hFFFF_8018, 8'd0, 2'b00, 8'hFF, NONE, 0);
    run_txn(1'b0, 32'h18, 8'd0, 2'b00, 8'hFF, NONE, 0);

    // Oversized len clipped to MAX_BEATS.
    run_txn(1'b0, 32'h100, 8'd40, 2'b01, 8'hFF, NONE, 0);

    // Valid dropped at beat 3 of an 8-beat write: beats 0..2 stay.
    for (int j = 0; j < 8; j++) wbuf[j] = {$urandom, $urandom};
    run_txn(1'b1, 32'h300, 8'd7, 2'b01, 8'hFF, 3, 1);
    run_txn(1'b0, 32'h300, 8'd7, 2'b01, 8'hFF, NONE, 0);

    // Reset at beat 7 of a 16-beat write: beats 0..6 stay.
    for (int j = 0; j < 16; j++) wbuf[j] = {$urandom, $urandom};
    run_txn(1'b1, 32'h400, 8'd15, 2'b01, 8'hFF, 7, 2);
    @(posedge clk); #1;
    run_txn(1'b0, 32'h28, 8'd0, 2'b00, 8'hFF, NONE, 0);
    run_txn(1'b0, 32'h400, 8'd15, 2'b01, 8'hFF, NONE, 0);

    // Random traffic.
    for (int t = 0; t < 60; t++) begin
      ra = $urandom;
      rl = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(16, 255)) : 8'($urandom_range(0, 15));
      rb = 2'($urandom_range(0, 1));
      rs = 8'($urandom);
      rw = 1'($urandom_range(0, 1));
      for (int j = 0; j < 16; j++) wbuf[j] = {$urandom, $urandom};
      run_txn(rw, ra, rl, rb, rs, NONE, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cbus_mem_responder.md
Name: cbus_mem_responder

Overview:
- Cache-bus (cbus) responder: the memory end of the burst protocol driven by the data and instruction caches.
- Accepts cbus_req_t, serves single or burst reads and writes from an internal word-addressed RAM, and returns beats on cbus_resp_t.
- Used as the simulation and FPGA memory model behind the cache, and as the reference target for cache verification.

Parameters:
- ADDR_WORD_BITS, 12: RAM depth is 2^ADDR_WORD_BITS 64-bit words; word index = addr[3+ADDR_WORD_BITS-1:3].
- FIRST_BEAT_LATENCY, 2: cycles from request acceptance to the first ready beat (0..15).
- MAX_BEATS, 16: largest legal burst; longer len is clipped to MAX_BEATS.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous active-low reset.
- creq  input  $bits(cbus_req_t)  request: valid, is_write, size, addr, strobe, data, len, burst.
- cresp  output  $bits(cbus_resp_t)  response: ready, last, data.

Behaviour:
- Reset (reset low, asynchronous):
  - State goes to IDLE.
  - cresp.ready=0, cresp.last=0, cresp.data=0; beat counter, index and latency counter are cleared.
  - RAM contents are not cleared.
- Handshake:
  - The initiator raises creq.valid and holds every creq field stable until the cycle after the beat with ready&&last.
  - Each cycle with ready=1 is exactly one beat.
  - Read beat: cresp.data is valid in that same cycle.
  - Write beat: creq.data and creq.strobe are sampled at the rising edge ending that cycle.
- States:
  - IDLE: on creq.valid, latch addr, is_write, len and burst. Set beats_left=len+1 (clipped), idx=addr word index and lat=FIRST_BEAT_LATENCY. Go to WAIT, or directly to BEAT if the latency is 0.
  - WAIT: lat decrements each cycle; at 1 go to BEAT.
  - BEAT: ready=1 and last=(beats_left==1).
    - Read: cresp.data=ram[idx], read combinationally (zero-latency RAM).
    - Write: ram[idx] byte lanes where creq.strobe[i]=1 are updated at the edge.
    - After each beat, beats_left decrements. With AXI_BURST_INCR, idx = idx+1 mod 2^ADDR_WORD_BITS (wraps across the top of RAM, not within a line). With AXI_BURST_FIXED, idx is unchanged.
    - On the last beat go to DONE.
  - DONE: ready=0 for one cycle and creq.valid is ignored; then IDLE. A new request is therefore accepted no earlier than 2 cycles after last.
- Timing and outputs:
  - Latency: a single-beat read with FIRST_BEAT_LATENCY=2 has ready in the 3rd cycle after the valid edge.
  - A 16-beat burst has 16 consecutive ready cycles when no stalls are inserted.
  - cresp.data=0 whenever ready=0. last is never 1 while ready=0.
- Boundary conditions:
  - creq.valid dropping mid-transaction (protocol violation): return to IDLE next cycle; any partial write already committed stays.
  - size is informational only; the strobe alone selects bytes. A write with strobe=0 completes its beats without modifying RAM.
  - Address bits above the index are ignored (memory aliases).
  - Reset asserted mid-burst: outputs drop immediately (asynchronously); beats already written remain.

Optional Feature:
- Macro: CBUS_RANDOM_STALL_EN.
- Defined:
  - An internal 16-bit LFSR (seed 16'hACE1 on reset) advances every cycle.
  - In BEAT, when lfsr[1:0]==2'b00, ready is forced to 0 for that cycle (stall). No state, index or beat progress occurs, and a write is not committed.
  - Stalls can occur before any beat, including the first and last.
- Undefined: no stalls; beats are back-to-back as specified above.

Decomposition:
- cbus_req_t, cbus_resp_t, mlen/burst enums and MSIZE constants are already in package common; reuse them and add nothing new.
- Local state_t enum {IDLE, WAIT, BEAT, DONE} stays in the module.
- RAM: instantiate existing RAM_SinglePort (DATA_WIDTH 64, BYTE_WIDTH 8, READ_LATENCY 0).
- Sub-module cbus_stall_lfsr (clk, reset, stall output), instantiated only under CBUS_RANDOM_STALL_EN.

Test Plan:
- Single read: preload ram[5]=64'h1122334455667788; request addr=0x28, len=MLEN1, FIXED, read → one beat 3 cycles later with data=64'h1122334455667788, last=1.
- 16-beat INCR write then read: write addr=0x80 with data=i for beat i, strobe=8'hFF; read back → 16 consecutive ready beats with data 0..15 and last only on beat 15.
- Strobe merge: ram[0]=64'hFFFF_FFFF_FFFF_FFFF; write data=0, strobe=8'h0F → readback 64'hFFFF_FFFF_0000_0000.
- Wrap: ADDR_WORD_BITS=4, INCR 4 beats from word 14 → indices 14, 15, 0, 1 accessed.
- FIXED 4-beat write to 0x10 with data 1..4 → ram[2]=4; neighbouring words are unchanged.
- Reset mid-burst at beat 7 of 16: ready and last go 0 in the same cycle; after release, state is IDLE and the next single read completes normally. With CBUS_RANDOM_STALL_EN, the 16-beat readback still matches and the total cycle count is ≥16.
